// File: rtl/line_access_arbiter.sv
// line_access_arbiter: shares one single-port cache-line memory between the
// CPU and the external/snoop requester. One full line transaction per grant
// (write, or read with fixed latency), CPU-priority arbitration with a
// starvation limit so EXT always makes forward progress. All outputs are
// registered; a transaction is IDLE -> ACCESS -> [WAIT...] -> DONE -> IDLE.
module line_access_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int LINE_W    = 66,
  parameter int MEM_LAT   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [LINE_W-1:0] cpu_wline,
  output logic              cpu_gnt,
  output logic              cpu_done,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [LINE_W-1:0] ext_wline,
  output logic              ext_gnt,
  output logic              ext_done,
  output logic [LINE_W-1:0] rline,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [LINE_W-1:0] mem_wline,
  input  logic [LINE_W-1:0] mem_rline,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int LAT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wline;
  } req_t;

  state_t           state;
  logic             win_ext;     // owner of the transaction in flight
  logic             lat_we;      // latched direction of that transaction
  logic [CNT_W-1:0] starve_cnt;  // CPU grants made while EXT was waiting
  logic [LAT_W-1:0] lat_cnt;     // read cycles elapsed since ACCESS began

  logic pick_any;
  logic pick_ext;
  req_t sel;

  // Arbitration: CPU wins ties unless EXT has already sat out a full burst.
  always_comb begin
    pick_any = cpu_req | ext_req;
    pick_ext = ext_req & (~cpu_req | (starve_cnt == CNT_W'(MAX_BURST)));
    if (pick_ext) begin
      sel.we    = ext_we;
      sel.addr  = ext_addr;
      sel.wline = ext_wline;
    end else begin
      sel.we    = cpu_we;
      sel.addr  = cpu_addr;
      sel.wline = cpu_wline;
    end
  end

  // Transaction sequencer; mem_addr doubles as the latched address, and the
  // requester inputs are not looked at again until the next IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      win_ext    <= 1'b0;
      lat_we     <= 1'b0;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      cpu_gnt    <= 1'b0;
      cpu_done   <= 1'b0;
      ext_gnt    <= 1'b0;
      ext_done   <= 1'b0;
      rline      <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wline  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!ext_req) starve_cnt <= '0;
          if (pick_any) begin
            state    <= ACCESS;
            win_ext  <= pick_ext;
            lat_we   <= sel.we;
            mem_addr <= sel.addr;
            mem_we   <= sel.we;
            if (sel.we) mem_wline <= sel.wline;
            cpu_gnt  <= ~pick_ext;
            ext_gnt  <= pick_ext;
            busy     <= 1'b1;
            if (pick_ext)
              starve_cnt <= '0;
            else if (ext_req && starve_cnt != CNT_W'(MAX_BURST))
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (lat_we || MEM_LAT == 1) begin
            if (!lat_we) rline <= mem_rline;
            state    <= DONE;
            cpu_done <= ~win_ext;
            ext_done <= win_ext;
          end else begin
            lat_cnt <= LAT_W'(1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_W'(MEM_LAT - 1)) begin
            rline    <= mem_rline;
            state    <= DONE;
            cpu_done <= ~win_ext;
            ext_done <= win_ext;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          cpu_gnt  <= 1'b0;
          ext_gnt  <= 1'b0;
          cpu_done <= 1'b0;
          ext_done <= 1'b0;
          busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
